// File: rtl/key_fifo_seq_pkg.sv
// Shared types and helpers for the key-driven FIFO sequencer.
package key_fifo_seq_pkg;

    // Run-control states of the sequencer.
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        GAP,
        READ,
        STREAM
    } state_t;

    // Pointer width for a power-of-two FIFO: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/key_fifo_seq_fifo.sv
// Single-clock synchronous FIFO with registered read data and wrap-bit pointers.
module sync_fifo_core
    import key_fifo_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata,
    output logic                           full,
    output logic                           empty,
    output logic [ptr_width(DEPTH)-1:0]    count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic              do_push;
    logic              do_pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO succeeds alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (wptr == rptr);
    assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer advance and registered read port (data appears one cycle after the pop).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            rdata <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr  <= rptr + PW'(1);
                rdata <= mem[rptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/key_fifo_seq.sv
// Key-triggered write/read sequencer around a synchronous FIFO.
module key_fifo_seq
    import key_fifo_seq_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int BURST        = 10,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int RD_DIV       = 50000000,
    parameter int GAP_CYC      = 25000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         key,
    input  logic                         mode,
    output logic                         led_wr,
    output logic                         led_rd,
    output logic [DATA_W-1:0]            disp_data,
    output logic                         disp_valid,
    output logic [ptr_width(DEPTH)-1:0]  fifo_cnt,
    output logic                         full,
    output logic                         empty,
    output logic                         busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

    state_t            state;
    state_t            state_next;
    logic              key_meta;
    logic              key_sync;
    logic              key_stable;
    logic              press;
    logic [DB_W-1:0]   db_cnt;
    logic [31:0]       timer;
    logic [7:0]        wr_cnt;
    logic [DATA_W-1:0] next_val;
    logic              push;
    logic              pop;
    logic              push_ok;
    logic              pop_ok;
    logic              rd_tick;
    logic              half_tick;
    logic              gap_done;
    logic              burst_done;

    // Two-flop synchroniser for the asynchronous push button (idles high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

    // Debounce: the stable level follows only after DEBOUNCE_CYC consecutive differing samples; a 1->0 change pulses press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt     <= '0;
            key_stable <= 1'b1;
            press      <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_sync == key_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                db_cnt     <= '0;
                key_stable <= key_sync;
                press      <= key_stable;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign rd_tick    = (timer == 32'(RD_DIV - 1));
    assign half_tick  = (timer == 32'(RD_DIV / 2 - 1)) || rd_tick;
    assign gap_done   = (timer == 32'(GAP_CYC - 1));
    assign burst_done = (wr_cnt == 8'(BURST));

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next-state and FIFO strobe decode; presses outside IDLE are simply ignored.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    state_next = mode ? STREAM : WRITE;
                end
            end
            WRITE: begin
                if (full) begin
                    state_next = GAP;
                end else begin
                    push = 1'b1;
                    if (wr_cnt == 8'(BURST - 1)) begin
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (empty) begin
                    if (disp_valid || rd_tick) begin
                        state_next = IDLE;
                    end
                end else if (rd_tick) begin
                    pop = 1'b1;
                end
            end
            STREAM: begin
                push = half_tick && !burst_done;
                pop  = rd_tick && !empty;
                if (burst_done && empty) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, pacing timer, burst counter, running data value and display strobe.
    // next_val always holds the value of the next push, so at run exit it equals last pushed + 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            wr_cnt     <= '0;
            next_val   <= '0;
            disp_valid <= 1'b0;
        end else begin
            state      <= state_next;
            disp_valid <= pop_ok;
            if (state == IDLE || state_next != state) begin
                timer <= '0;
            end else if ((state == READ || state == STREAM) && rd_tick) begin
                timer <= '0;
            end else begin
                timer <= timer + 32'd1;
            end
            if (state == IDLE) begin
                wr_cnt <= '0;
            end else if (push_ok) begin
                wr_cnt <= wr_cnt + 8'd1;
            end
            if (push_ok) begin
                next_val <= next_val + DATA_W'(1);
            end
        end
    end

    assign led_wr = (state == WRITE) || (state == STREAM && !burst_done);
    assign led_rd = (state == READ || state == STREAM) && !empty;
    assign busy   = (state != IDLE);

    sync_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (next_val),
        .rdata (disp_data),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_key_fifo_seq.sv
// Scoreboard bench for key_fifo_seq: three instances with BURST 10, 20 and 12.
module tb_key_fifo_seq;

    localparam int RD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [2:0] key_v;
    logic [2:0] led_wr_v, led_rd_v, dv_v, full_v, empty_v, busy_v;
    logic [7:0] disp_v [3];
    logic [4:0] cnt_v [3];

    int compared   = 0;
    int mismatched = 0;
    int exp_q[$];
    int cyc = 0;
    int last_pop[3] = '{-1, -1, -1};
    int seed_a = 0;

    // 100 MHz-style free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    key_fifo_seq #(.DATA_W(8), .DEPTH(16), .BURST(10), .DEBOUNCE_CYC(16), .RD_DIV(RD), .GAP_CYC(20)) dut_a (
        .clk(clk), .rst_n(rst_n), .key(key_v[0]), .mode(mode),
        .led_wr(led_wr_v[0]), .led_rd(led_rd_v[0]), .disp_data(disp_v[0]), .disp_valid(dv_v[0]),
        .fifo_cnt(cnt_v[0]), .full(full_v[0]), .empty(empty_v[0]), .busy(busy_v[0]));

    key_fifo_seq #(.DATA_W(8), .DEPTH(16), .BURST(20), .DEBOUNCE_CYC(16), .RD_DIV(RD), .GAP_CYC(20)) dut_b (
        .clk(clk), .rst_n(rst_n), .key(key_v[1]), .mode(mode),
        .led_wr(led_wr_v[1]), .led_rd(led_rd_v[1]), .disp_data(disp_v[1]), .disp_valid(dv_v[1]),
        .fifo_cnt(cnt_v[1]), .full(full_v[1]), .empty(empty_v[1]), .busy(busy_v[1]));

    key_fifo_seq #(.DATA_W(8), .DEPTH(16), .BURST(12), .DEBOUNCE_CYC(16), .RD_DIV(RD), .GAP_CYC(20)) dut_c (
        .clk(clk), .rst_n(rst_n), .key(key_v[2]), .mode(mode),
        .led_wr(led_wr_v[2]), .led_rd(led_rd_v[2]), .disp_data(disp_v[2]), .disp_valid(dv_v[2]),
        .fifo_cnt(cnt_v[2]), .full(full_v[2]), .empty(empty_v[2]), .busy(busy_v[2]));

    // Output monitor: every display strobe pops the scoreboard and checks the read pacing.
    always @(negedge clk) begin : monitor
        int e;
        for (int d = 0; d < 3; d++) begin
            if (dv_v[d] === 1'b1) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_pop dut%0d: got %0d, expected no output", d, disp_v[d]);
                end else begin
                    e = exp_q.pop_front();
                    if ((e / 256) != d || disp_v[d] !== 8'(e % 256)) begin
                        mismatched++;
                        $display("[TB] FAIL disp_data dut%0d: got %0d, expected dut%0d value %0d", d, disp_v[d], e / 256, e % 256);
                    end
                end
                if (last_pop[d] >= 0) begin
                    compared++;
                    if (cyc - last_pop[d] != RD) begin
                        mismatched++;
                        $display("[TB] FAIL pop_spacing dut%0d: got %0d cycles, expected %0d", d, cyc - last_pop[d], RD);
                    end
                end
                last_pop[d] = cyc;
            end
        end
    end

    task automatic expect_run(input int d, input int start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(d * 256 + ((start + i) % 256));
    endtask

    // Presses key d for low cycles and follows the run until busy drops, gathering statistics.
    task automatic run_dut(input int d, input int low, output int wr_cycles, output int max_cnt,
                           output bit saw_full, output bit saw_rd, output bit ok);
        bit started = 1'b0;
        wr_cycles = 0; max_cnt = 0; saw_full = 1'b0; saw_rd = 1'b0; ok = 1'b0;
        last_pop[d] = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            key_v[d] = (i < low) ? 1'b0 : 1'b1;
            if (led_wr_v[d]) wr_cycles++;
            if (int'(cnt_v[d]) > max_cnt) max_cnt = int'(cnt_v[d]);
            if (full_v[d]) saw_full = 1'b1;
            if (led_rd_v[d]) saw_rd = 1'b1;
            if (busy_v[d]) started = 1'b1;
            else if (started) begin
                ok = 1'b1;
                break;
            end
        end
        key_v[d] = 1'b1;
    endtask

    task automatic test_reset();
        bit saw_busy = 1'b0;
        rst_n = 1'b0; key_v = 3'b111; mode = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            compared++;
            if ({busy_v[d], empty_v[d], full_v[d], led_wr_v[d], led_rd_v[d], dv_v[d]} !== 6'b010000) begin
                mismatched++;
                $display("[TB] FAIL reset_flags dut%0d: got %b, expected 010000", d,
                         {busy_v[d], empty_v[d], full_v[d], led_wr_v[d], led_rd_v[d], dv_v[d]});
            end
            compared++;
            if (cnt_v[d] !== 5'd0 || disp_v[d] !== 8'd0) begin
                mismatched++;
                $display("[TB] FAIL reset_values dut%0d: got cnt %0d disp %0d, expected 0 0", d, cnt_v[d], disp_v[d]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            key_v[0] = (i < 10) ? 1'b0 : 1'b1;
            if (busy_v[0]) saw_busy = 1'b1;
        end
        compared++;
        if (saw_busy || empty_v[0] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL glitch_ignored: got busy_seen %0b empty %0b, expected 0 1", saw_busy, empty_v[0]);
        end
    endtask

    task automatic test_burst();
        int wr, mx; bit sf, sr, ok;
        expect_run(0, seed_a, 10);
        run_dut(0, 40, wr, mx, sf, sr, ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL burst_done: got timeout, expected return to idle"); end
        compared++;
        if (wr != 10 || mx != 10) begin
            mismatched++;
            $display("[TB] FAIL burst_write: got led_wr %0d cnt peak %0d, expected 10 10", wr, mx);
        end
        compared++;
        if (!sr || sf || empty_v[0] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL burst_flags: got led_rd_seen %0b full_seen %0b empty %0b, expected 1 0 1", sr, sf, empty_v[0]);
        end
        compared++;
        if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL burst_drain: got %0d left, expected 0", exp_q.size()); end
        seed_a = 10;
    endtask

    task automatic test_seed_wrap();
        int wr, mx; bit sf, sr, ok;
        while (1) begin
            expect_run(0, seed_a, 10);
            run_dut(0, 40, wr, mx, sf, sr, ok);
            compared++;
            if (!ok) begin mismatched++; $display("[TB] FAIL seed_run %0d: got timeout, expected idle", seed_a); end
            if (seed_a == 250) break;
            seed_a = (seed_a + 10) % 256;
        end
        compared++;
        if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL wrap_drain: got %0d left, expected 0", exp_q.size()); end
        seed_a = 4;
    endtask

    task automatic test_full_stop();
        int wr, mx; bit sf, sr, ok;
        expect_run(1, 0, 16);
        run_dut(1, 40, wr, mx, sf, sr, ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL full_done: got timeout, expected idle"); end
        compared++;
        if (mx != 16 || !sf || wr != 17) begin
            mismatched++;
            $display("[TB] FAIL full_stop: got peak %0d full_seen %0b led_wr %0d, expected 16 1 17", mx, sf, wr);
        end
        compared++;
        if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL full_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_stream();
        int wr, mx; bit sf, sr, ok;
        mode = 1'b1;
        expect_run(2, 0, 12);
        run_dut(2, 40, wr, mx, sf, sr, ok);
        mode = 1'b0;
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL stream_done: got timeout, expected idle"); end
        compared++;
        if (mx != 6 || wr != 48) begin
            mismatched++;
            $display("[TB] FAIL stream_rate: got peak %0d led_wr %0d, expected 6 48", mx, wr);
        end
        compared++;
        if (empty_v[2] !== 1'b1 || busy_v[2] !== 1'b0 || exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL stream_end: got empty %0b busy %0b left %0d, expected 1 0 0", empty_v[2], busy_v[2], exp_q.size());
        end
    endtask

    task automatic test_press_in_read();
        int  pops = 0;
        int  p2 = -1;
        bit  started = 1'b0;
        bit  ok = 1'b0;
        bit  rose = 1'b0;
        expect_run(0, seed_a, 10);
        last_pop[0] = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (dv_v[0]) begin
                pops++;
                if (pops == 2 && p2 < 0) p2 = i + 1;
            end
            key_v[0] = (i < 25 || (p2 >= 0 && i >= p2 && i < p2 + 30)) ? 1'b0 : 1'b1;
            if (busy_v[0]) started = 1'b1;
            else if (started) begin ok = 1'b1; break; end
        end
        key_v[0] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy_v[0]) rose = 1'b1;
        end
        compared++;
        if (!ok || p2 < 0) begin
            mismatched++;
            $display("[TB] FAIL read_press_run: got done %0b press_at %0d, expected done with press in READ", ok, p2);
        end
        compared++;
        if (rose || exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL read_press_ignored: got restart %0b left %0d, expected 0 0", rose, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int wr, mx; bit sf, sr, ok;
        bit in_write = 1'b0;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            key_v[1] = (i < 25) ? 1'b0 : 1'b1;
        end
        in_write = led_wr_v[1];
        compared++;
        if (in_write !== 1'b1 || cnt_v[1] == 5'd0) begin
            mismatched++;
            $display("[TB] FAIL mid_write: got led_wr %0b cnt %0d, expected 1 and nonzero", in_write, cnt_v[1]);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if ({busy_v[1], empty_v[1], full_v[1], led_wr_v[1], led_rd_v[1], dv_v[1]} !== 6'b010000
            || cnt_v[1] !== 5'd0 || disp_v[1] !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset: got flags %b cnt %0d disp %0d, expected 010000 0 0",
                     {busy_v[1], empty_v[1], full_v[1], led_wr_v[1], led_rd_v[1], dv_v[1]}, cnt_v[1], disp_v[1]);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        expect_run(1, 0, 16);
        run_dut(1, 40, wr, mx, sf, sr, ok);
        compared++;
        if (!ok || mx != 16 || exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL restart_after_reset: got done %0b peak %0d left %0d, expected 1 16 0", ok, mx, exp_q.size());
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_burst();
        test_seed_wrap();
        test_full_stop();
        test_stream();
        test_press_in_read();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/key_fifo_seq.md
Name: key_fifo_seq

Overview:
Parametrised single-clock successor to the key-driven FIFO demo top. A debounced key press starts a write/read run through an internal synchronous FIFO. Data width, depth, burst length, read pacing and debounce time are parameters. A run-time mode selects burst-then-drain or concurrent streaming. Outputs drive the write/read LEDs and a display-value bus for the downstream seven-segment driver.

Parameters:
DATA_W, 8, FIFO word width, data wraps modulo 2^DATA_W
DEPTH, 16, FIFO depth in words, power of two, >=4
BURST, 10, words written per run, 1..255
DEBOUNCE_CYC, 1000000, stable-low cycles to accept a press (20 ms at 50 MHz)
RD_DIV, 50000000, cycles between reads (pop pacing), >=2
GAP_CYC, 25000000, idle cycles between WRITE end and READ start (mode 0)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
key  in  1  raw push button, active low, asynchronous to clk
mode  in  1  0 = burst then drain, 1 = concurrent stream; sampled on press acceptance
led_wr  out  1  high while FSM in WRITE (mode 0) or while writes are pending (mode 1)
led_rd  out  1  high while FSM in READ or STREAM with FIFO non-empty
disp_data  out  DATA_W  last word popped from FIFO
disp_valid  out  1  one-cycle pulse when disp_data updates
fifo_cnt  out  $clog2(DEPTH)+1  current occupancy
full  out  1  FIFO full
empty  out  1  FIFO empty
busy  out  1  FSM not IDLE

Behaviour:
- Reset values: FSM=IDLE, all outputs 0 except empty=1. Seed register=0, FIFO pointers=0.
- Key path: 2-flop synchroniser, then counter. The stable level changes only after DEBOUNCE_CYC consecutive equal samples. A press event is a 1-cycle pulse on the stable 1->0 transition. Release generates nothing.
- Press accepted only in IDLE. Presses while busy are discarded, not queued.
- FSM states: IDLE, WRITE, GAP, READ, STREAM.
  - IDLE -> WRITE (mode=0) or STREAM (mode=1) on the cycle after the accepted press.
  - WRITE: push one word per cycle. Values are seed, seed+1, ... (mod 2^DATA_W). Leave for GAP after BURST pushes or when full blocks the next push. Words not written are dropped, not retried.
  - GAP: count GAP_CYC cycles, then go to READ.
  - READ: pop one word every RD_DIV cycles. First pop RD_DIV cycles after entry. Return to IDLE on the cycle empty is seen after a pop.
  - STREAM: push one word every RD_DIV/2 cycles until BURST pushes. Pop every RD_DIV cycles when not empty. A push while full is skipped and retried next push slot. Return to IDLE when BURST pushed and FIFO empty.
- Seed: updated to last pushed value + 1 on run exit, so consecutive runs continue the sequence.
- FIFO read latency: disp_data and disp_valid are registered 1 cycle after the pop strobe.
- Simultaneous push and pop in the same cycle: fifo_cnt unchanged, both succeed. A push when full without a same-cycle pop is blocked. A pop when empty is blocked.
- Pointers are $clog2(DEPTH)+1 bits with MSB wrap. full = MSBs differ and remaining bits are equal. empty = pointers equal.
- Reset mid-run: immediate return to reset values. FIFO contents are invalidated (count=0), seed=0.

Decomposition:
- Shared package: FSM state enum (IDLE, WRITE, GAP, READ, STREAM) and pointer-width function (clog2+1).
- One sub-module: sync_fifo_core (DATA_W, DEPTH; push, pop, wdata, rdata, full, empty, count). It is also reusable elsewhere.
- The debouncer stays inline.

Test Plan:
All scenarios use DEBOUNCE_CYC=16, RD_DIV=8, GAP_CYC=20, DEPTH=16, DATA_W=8.
1. Reset then key low for 10 cycles (glitch) -> no press, busy=0, empty=1.
2. mode=0, BURST=10, key low 40 cycles -> 10 consecutive push cycles with led_wr=1. fifo_cnt reaches 10. After GAP, led_rd=1 and disp_data steps 0..9 every 8 cycles. Back to IDLE, seed=10.
3. Second press, same config -> disp_data steps 10..19. Run with seed=250 -> values wrap 250..255,0..3.
4. mode=0, BURST=20 -> write stops at fifo_cnt=16 with full=1. Only 16 reads (0..15), seed=16.
5. mode=1, BURST=12 -> push every 4 cycles, pop every 8. fifo_cnt peaks at 6. disp_data 0..11 in order. Ends with empty=1, busy=0.
6. Press during READ ignored. rst_n low mid-WRITE -> all outputs 0, empty=1. A later press restarts from 0.
